// File: rtl/bf_sched_ctrl.sv
// Butterfly pass sequencer: pops coefficient pairs, issues them with stage-dependent
// twiddle addresses, and tracks in-flight results against output FIFO credit.
module bf_sched_ctrl #(
  parameter int ADDRBIT = 4,
  parameter int LOGN    = 8,
  parameter int SW      = 3,
  parameter int RDLAT   = 1,
  parameter int BF_LAT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [SW-1:0]      stage,
  output logic               busy,
  output logic               done,
  input  logic               in_notempty,
  output logic               in_rd,
  input  logic [ADDRBIT:0]   out_len,
  output logic               out_wr,
  output logic               bf_valid,
  output logic               bf_mode,
  output logic [LOGN-1:0]    twid_addr
);

  localparam int D  = 1 << ADDRBIT;
  localparam int NP = 1 << (LOGN - 1);
  localparam logic [LOGN-1:0]    NP_L    = LOGN'(NP);
  localparam logic [LOGN-1:0]    NP_LAST = LOGN'(NP - 1);
  localparam logic [ADDRBIT+1:0] D_L     = (ADDRBIT + 2)'(D);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic [SW-1:0]      stage_q;
  logic [LOGN-1:0]    issued;
  logic [LOGN-1:0]    written;
  logic [ADDRBIT:0]   inflight;
  logic [ADDRBIT+1:0] credit_sum;
  logic               issue;
  logic [LOGN-1:0]    twid_p0;
  logic [RDLAT-1:0]   vld_p1;
  logic [LOGN-1:0]    twid_p1 [RDLAT];
  logic [BF_LAT-1:0]  vld_p2;

  function automatic logic [SW-1:0] clamp_stage(input logic [SW-1:0] s);
    if (int'(s) >= LOGN) return SW'(LOGN - 1);
    return s;
  endfunction

  // Forward walks up from 2^stage, inverse walks down from 2^(stage+1)-1.
  function automatic logic [LOGN-1:0] twid_calc(input logic m, input logic [SW-1:0] st,
                                                input logic [LOGN-1:0] idx);
    logic [LOGN:0] base;
    logic [LOGN:0] g;
    base = (LOGN + 1)'(1) << st;
    g    = {1'b0, idx >> (LOGN - 1 - int'(st))};
    if (m) return LOGN'((base << 1) - (LOGN + 1)'(1) - g);
    return LOGN'(base + g);
  endfunction

  // Credit uses this cycle's occupancy; a concurrent pop downstream only costs throughput.
  assign credit_sum = {1'b0, inflight} + {1'b0, out_len};
  assign issue      = !rst && (state == RUN) && in_notempty && (credit_sum < D_L) && (issued < NP_L);
  assign in_rd      = issue;
  assign twid_p0    = twid_calc(bf_mode, stage_q, issued);
  assign bf_valid   = vld_p1[RDLAT-1];
  assign twid_addr  = twid_p1[RDLAT-1];
  assign out_wr     = vld_p2[BF_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_mode  <= 1'b0;
      stage_q  <= '0;
      issued   <= '0;
      written  <= '0;
      inflight <= '0;
    end else begin
      done <= 1'b0;
      if (issue)  issued  <= issued + 1'b1;
      if (out_wr) written <= written + 1'b1;
      case ({issue, out_wr})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case (state)
        IDLE: if (start) begin
          bf_mode <= mode;
          stage_q <= clamp_stage(stage);
          issued  <= '0;
          written <= '0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: if (issue && issued == NP_LAST) state <= DRAIN;
        DRAIN: if (out_wr && written == NP_LAST) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0->p1: input FIFO read latency; p1->p2: butterfly latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= '0;
      vld_p2 <= '0;
      for (int i = 0; i < RDLAT; i++) twid_p1[i] <= '0;
    end else begin
      vld_p1[0]  <= issue;
      twid_p1[0] <= twid_p0;
      for (int i = 1; i < RDLAT; i++) begin
        vld_p1[i]  <= vld_p1[i-1];
        twid_p1[i] <= twid_p1[i-1];
      end
      vld_p2[0] <= vld_p1[RDLAT-1];
      for (int i = 1; i < BF_LAT; i++) vld_p2[i] <= vld_p2[i-1];
    end
  end

endmodule

// File: tb/tb_bf_sched_ctrl.sv
// Scoreboard bench for bf_sched_ctrl: issue events queue expected twiddle/timing,
// butterfly and write events pop and compare.
module tb_bf_sched_ctrl;
  localparam int NP = 128, D = 16, RDLAT = 1, BF_LAT = 3;

  logic       clk = 1'b0;
  logic       rst, start, mode, in_notempty;
  logic [2:0] stage;
  logic [4:0] out_len;
  logic       busy, done, in_rd, out_wr, bf_valid, bf_mode;
  logic [7:0] twid_addr;

  bf_sched_ctrl #(.ADDRBIT(4), .LOGN(8), .SW(3), .RDLAT(RDLAT), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stage(stage), .busy(busy),
    .done(done), .in_notempty(in_notempty), .in_rd(in_rd), .out_len(out_len),
    .out_wr(out_wr), .bf_valid(bf_valid), .bf_mode(bf_mode), .twid_addr(twid_addr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int cyc; int tw; int idx;} ent_t;
  ent_t rdq[$];
  int   wrq[$];
  int   checks = 0, failures = 0;
  int   m_mode, m_stage, m_issued, m_written, m_inflight, max_inflight;
  int   rd_cnt, done_cnt, first_rd, last_rd, done_cyc;
  int   tw_seen [NP];

  function automatic int model_twid(int m, int st, int idx);
    int g;
    g = idx >> (7 - st);
    if (m != 0) return (2 << st) - 1 - g;
    return (1 << st) + g;
  endfunction

  // Monitor: legality of each pop, then expected bf/write timing and twiddle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (in_rd === 1'b1) begin
        checks++;
        if (!(in_notempty === 1'b1 && m_inflight + int'(out_len) < D && m_issued < NP)) begin
          failures++;
          $display("FAIL rd_legal cyc=%0d notempty=%b inflight=%0d out_len=%0d issued=%0d",
                   cyc, in_notempty, m_inflight, out_len, m_issued);
        end
        rdq.push_back('{cyc + RDLAT, model_twid(m_mode, m_stage, m_issued), m_issued});
        m_issued++;
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (bf_valid === 1'b1) begin
        ent_t e;
        checks++;
        if (rdq.size() == 0) begin
          failures++;
          $display("FAIL bf_unexpected cyc=%0d got bf_valid=1 required 0", cyc);
        end else begin
          e = rdq.pop_front();
          tw_seen[e.idx] = int'(twid_addr);
          if (cyc != e.cyc || int'(twid_addr) != e.tw) begin
            failures++;
            $display("FAIL bf_twid idx=%0d got cyc=%0d tw=%0d required cyc=%0d tw=%0d",
                     e.idx, cyc, twid_addr, e.cyc, e.tw);
          end
        end
        wrq.push_back(cyc + BF_LAT);
      end
      if (out_wr === 1'b1) begin
        int w;
        checks++;
        if (wrq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected cyc=%0d got out_wr=1 required 0", cyc);
        end else begin
          w = wrq.pop_front();
          if (cyc != w) begin
            failures++;
            $display("FAIL wr_time got cyc=%0d required %0d", cyc, w);
          end
        end
        m_written++;
      end
      m_inflight = m_inflight + (in_rd === 1'b1 ? 1 : 0) - (out_wr === 1'b1 ? 1 : 0);
      if (m_inflight > max_inflight) max_inflight = m_inflight;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0 || m_written != NP) begin
          failures++;
          $display("FAIL done_state got busy=%b written=%0d required busy=0 written=%0d",
                   busy, m_written, NP);
        end
      end
    end
  end

  task automatic clear_model();
    rdq.delete();
    wrq.delete();
    m_issued = 0; m_written = 0; m_inflight = 0; max_inflight = 0;
    rd_cnt = 0; done_cnt = 0; first_rd = -1; last_rd = -1; done_cyc = -1;
    for (int i = 0; i < NP; i++) tw_seen[i] = -1;
  endtask

  // pat: 0 free-running, 1 backpressure, 2 starvation, 3 start while busy, 4 reset after 50 issues
  task automatic run_pass(input int m, input int st, input int pat, output int s);
    bit finished;
    clear_model();
    m_mode = m; m_stage = st;
    finished = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = m[0]; stage = 3'(st); in_notempty = 1'b1; out_len = '0;
    s = cyc;
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt > 0) begin finished = 1'b1; break; end
      case (pat)
        1: begin
          out_len = (k <= 40) ? 5'd12 : 5'd0;
          if (k == 41) begin
            @(negedge clk);
            checks++;
            if (in_rd !== 1'b1) begin
              failures++;
              $display("FAIL bp_resume got in_rd=%b required 1", in_rd);
            end
          end
        end
        2: in_notempty = (k % 2 == 1);
        3: begin
          if (k == 10) begin start = 1'b1; mode = ~m[0]; stage = 3'd5; end
          if (k == 133) start = 1'b1;
        end
        4: if (m_issued >= 50) begin rst = 1'b1; finished = 1'b1; break; end
        default: ;
      endcase
    end
    in_notempty = 1'b1; out_len = '0; start = 1'b0;
    if (!finished) begin
      checks++; failures++;
      $display("FAIL pass_timeout got no done within 3000 cycles required done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; stage = '0; in_notempty = 1'b0; out_len = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, in_rd, out_wr, bf_valid, bf_mode, twid_addr} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b %b %b %b %b %b %0d required all 0",
               busy, done, in_rd, out_wr, bf_valid, bf_mode, twid_addr);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, in_rd, out_wr, bf_valid} !== 5'd0) begin
      failures++;
      $display("FAIL idle_outputs got busy=%b done=%b in_rd=%b required 0", busy, done, in_rd);
    end
  endtask

  task automatic test_full_pass();
    int s;
    run_pass(0, 0, 0, s);
    checks++;
    if (first_rd != s + 1 || last_rd != s + 128 || rd_cnt != NP) begin
      failures++;
      $display("FAIL full_rd got first=%0d last=%0d cnt=%0d required %0d %0d %0d",
               first_rd - s, last_rd - s, rd_cnt, 1, 128, NP);
    end
    checks++;
    if (done_cyc != s + 133 || done_cnt != 1 || m_written != NP) begin
      failures++;
      $display("FAIL full_done got cyc=%0d cnt=%0d wr=%0d required 133 1 %0d",
               done_cyc - s, done_cnt, m_written, NP);
    end
    checks++;
    if (tw_seen[0] != 1 || tw_seen[64] != 1 || tw_seen[127] != 1 || rdq.size() != 0 || wrq.size() != 0) begin
      failures++;
      $display("FAIL full_twid got %0d %0d %0d required 1 1 1", tw_seen[0], tw_seen[64], tw_seen[127]);
    end
  endtask

  task automatic test_twiddle();
    int s;
    run_pass(0, 2, 0, s);
    checks++;
    if (tw_seen[0] != 4 || tw_seen[31] != 4 || tw_seen[32] != 5 || tw_seen[127] != 7) begin
      failures++;
      $display("FAIL twid_fwd2 got %0d %0d %0d %0d required 4 4 5 7",
               tw_seen[0], tw_seen[31], tw_seen[32], tw_seen[127]);
    end
    run_pass(1, 2, 0, s);
    checks++;
    if (tw_seen[0] != 7 || tw_seen[31] != 7 || tw_seen[32] != 6 || tw_seen[127] != 4) begin
      failures++;
      $display("FAIL twid_inv2 got %0d %0d %0d %0d required 7 7 6 4",
               tw_seen[0], tw_seen[31], tw_seen[32], tw_seen[127]);
    end
    run_pass(0, 7, 0, s);
    checks++;
    if (tw_seen[0] != 128 || tw_seen[127] != 255 || done_cnt != 1) begin
      failures++;
      $display("FAIL twid_fwd7 got %0d %0d required 128 255", tw_seen[0], tw_seen[127]);
    end
  endtask

  task automatic test_backpressure();
    int s;
    run_pass(0, 3, 1, s);
    checks++;
    if (max_inflight != 4) begin
      failures++;
      $display("FAIL bp_inflight got max=%0d required 4", max_inflight);
    end
    checks++;
    if (m_written != NP || rd_cnt != NP || done_cnt != 1) begin
      failures++;
      $display("FAIL bp_count got wr=%0d rd=%0d done=%0d required %0d %0d 1",
               m_written, rd_cnt, done_cnt, NP, NP);
    end
  endtask

  task automatic test_starvation();
    int s;
    run_pass(1, 5, 2, s);
    checks++;
    if (m_written != NP || rd_cnt != NP || done_cnt != 1 || rdq.size() != 0 || wrq.size() != 0) begin
      failures++;
      $display("FAIL starve_count got wr=%0d rd=%0d done=%0d required %0d %0d 1",
               m_written, rd_cnt, done_cnt, NP, NP);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    run_pass(0, 1, 4, s);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, in_rd, out_wr, bf_valid, bf_mode, twid_addr} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b in_rd=%b out_wr=%b bf_valid=%b tw=%0d required all 0",
               busy, in_rd, out_wr, bf_valid, twid_addr);
    end
    clear_model();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || m_written != 0) begin
      failures++;
      $display("FAIL mid_stray got done=%0d wr=%0d required 0 0", done_cnt, m_written);
    end
    run_pass(0, 1, 0, s);
    checks++;
    if (m_written != NP || done_cnt != 1 || first_rd != s + 1 || done_cyc != s + 133) begin
      failures++;
      $display("FAIL mid_rerun got wr=%0d done=%0d first=%0d dcyc=%0d required %0d 1 1 133",
               m_written, done_cnt, first_rd - s, done_cyc - s, NP);
    end
  endtask

  task automatic test_start_busy();
    int s;
    int bad;
    run_pass(0, 2, 3, s);
    checks++;
    if (done_cnt != 1 || tw_seen[32] != 5 || tw_seen[127] != 7 || m_written != NP) begin
      failures++;
      $display("FAIL busy_start got done=%0d tw32=%0d tw127=%0d required 1 5 7",
               done_cnt, tw_seen[32], tw_seen[127]);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || in_rd !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL done_start got %0d busy cycles required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_twiddle();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
